// File: rtl/aes_pkg.sv
// -----------------------------------------------------------------------------
// aes_pkg
// Shared AES definitions for the iterative round datapath.
//   AES_STATE_W / AES_BYTE_W / AES_NBYTES : state geometry
//   aes_fsm_e                             : engine FSM states (IDLE, BUSY, DONE)
//   byte_msb(i)                           : MSB position of byte i in a state,
//                                           byte 0 at [127:120], byte 15 at [7:0]
//   get_byte(st, i)                       : extract byte i from a state
// -----------------------------------------------------------------------------
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;
    localparam int AES_NBYTES  = AES_STATE_W / AES_BYTE_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } aes_fsm_e;

    // Column-major FIPS-197 ordering: byte i lives at [127-8i -: 8].
    function automatic int byte_msb(input int i);
        return AES_STATE_W - 1 - (AES_BYTE_W * i);
    endfunction

    function automatic logic [AES_BYTE_W-1:0] get_byte(
        input logic [AES_STATE_W-1:0] st,
        input int                     i
    );
        return st[byte_msb(i) -: AES_BYTE_W];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// -----------------------------------------------------------------------------
// aes_sbox
// Purely combinational FIPS-197 forward S-box.
//   a : input byte
//   c : substituted byte S(a)
// The table is stored row-major: entry for a lives at [2047-8a -: 8].
// -----------------------------------------------------------------------------
module aes_sbox
    import aes_pkg::*;
(
    input  logic [AES_BYTE_W-1:0] a,
    output logic [AES_BYTE_W-1:0] c
);

    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup indexed by the input byte.
    always_comb begin
        c = SBOX_TABLE[2047 - (8 * int'(a)) -: 8];
    end

endmodule

// File: rtl/aes_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// aes_sub_bytes_seq
// Sequential AES SubBytes engine. Accepts one 128-bit state, substitutes
// BYTES_PER_CYCLE bytes per clock in place, then presents the result until
// the downstream stage takes it.
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : input handshake, in_state captured on accept
//   in_state [127:0]     : input state (byte 0 at [127:120])
//   out_valid / out_ready: output handshake
//   out_state [127:0]    : substituted state, driven from the state register
//   busy                 : engine is in BUSY or DONE
// -----------------------------------------------------------------------------
module aes_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int BYTES_PER_CYCLE = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int NCHUNK  = AES_NBYTES / BYTES_PER_CYCLE;
    localparam int CNT_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHUNK_W = BYTES_PER_CYCLE * AES_BYTE_W;

    if (!((BYTES_PER_CYCLE == 1) || (BYTES_PER_CYCLE == 2) || (BYTES_PER_CYCLE == 4) ||
          (BYTES_PER_CYCLE == 8) || (BYTES_PER_CYCLE == 16))) begin : g_bad_bpc
        $error("aes_sub_bytes_seq: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end

    aes_fsm_e               state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [AES_STATE_W-1:0] data_r;
    logic                   ready_r;
    logic                   valid_r;

    logic [CHUNK_W-1:0]     chunk_in_s;
    logic [CHUNK_W-1:0]     chunk_out_s;
    logic [AES_STATE_W-1:0] data_next_s;
    logic                   last_chunk_s;

    // Select the current chunk and merge its substituted bytes back in place.
    always_comb begin
        chunk_in_s   = data_r[byte_msb(int'(cnt_r) * BYTES_PER_CYCLE) -: CHUNK_W];
        data_next_s  = data_r;
        data_next_s[byte_msb(int'(cnt_r) * BYTES_PER_CYCLE) -: CHUNK_W] = chunk_out_s;
        last_chunk_s = (cnt_r == CNT_W'(NCHUNK - 1));
    end

    for (genvar b = 0; b < BYTES_PER_CYCLE; b++) begin : g_sbox
        aes_sbox u_sbox (
            .a (chunk_in_s [CHUNK_W - 1 - (AES_BYTE_W * b) -: AES_BYTE_W]),
            .c (chunk_out_s[CHUNK_W - 1 - (AES_BYTE_W * b) -: AES_BYTE_W])
        );
    end

    // Engine FSM: capture, chunk-by-chunk substitution, hold until handoff.
    // ready_r resets low so in_ready stays 0 while reset is asserted and
    // comes up on the first clock after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            data_r  <= '0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && ready_r) begin
                        data_r  <= in_state;
                        cnt_r   <= '0;
                        ready_r <= 1'b0;
                        state_r <= BUSY;
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                BUSY: begin
                    data_r <= data_next_s;
                    if (last_chunk_s) begin
                        cnt_r   <= '0;
                        valid_r <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                DONE: begin
                    // Handoff returns to IDLE; no new state is taken this cycle.
                    if (out_ready) begin
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        state_r <= IDLE;
                    end else begin
                        valid_r <= 1'b1;
                    end
                end
                default: begin
                    cnt_r   <= '0;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = ready_r;
    assign out_valid = valid_r;
    assign out_state = data_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_aes_sub_bytes_seq.sv
// -----------------------------------------------------------------------------
// tb_aes_sub_bytes_seq
// Self-checking bench: five engines (BYTES_PER_CYCLE 4, 1, 2, 8, 16) share
// clock and reset. The reference S-box is derived algebraically (GF(2^8)
// inverse followed by the affine map). Instance 0 is also watched by a
// scoreboard that queues the expected result on every accept and compares
// it on every handoff.
// -----------------------------------------------------------------------------
module tb_aes_sub_bytes_seq;

    localparam int NINST = 5;

    function automatic int bpc_of(input int g);
        case (g)
            0:       return 4;
            1:       return 1;
            2:       return 2;
            3:       return 8;
            default: return 16;
        endcase
    endfunction

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid  [NINST];
    logic         in_ready  [NINST];
    logic [127:0] in_state  [NINST];
    logic         out_valid [NINST];
    logic         out_ready [NINST];
    logic [127:0] out_state [NINST];
    logic         busy      [NINST];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NINST; g++) begin : g_dut
        aes_sub_bytes_seq #(.BYTES_PER_CYCLE(bpc_of(g))) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_state  (in_state[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_state (out_state[g]),
            .busy      (busy[g])
        );
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] sbox_ref [256];

    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = x;
        logic [7:0] bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ((aa << 1) ^ 8'h1b) : (aa << 1);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_calc(input logic [7:0] x);
        logic [7:0] inv = 8'h00;
        for (int y = 1; y < 256; y++) begin
            if (gf_mul(x, 8'(y)) == 8'h01) inv = 8'(y);
        end
        return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_state(input logic [127:0] st);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = sbox_ref[st[127 - 8*i -: 8]];
        return r;
    endfunction

    // ---------------- scoreboard on instance 0 ----------------
    logic [127:0] sb_q [$];
    int           sb_pops = 0;

    // Inputs change just after posedge, so the negedge sees what the next edge will act on.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (in_valid[0] && in_ready[0]) sb_q.push_back(sub_state(in_state[0]));
            if (out_valid[0] && out_ready[0]) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %h, expected no output", out_state[0]);
                end else begin
                    check("sb_data", out_state[0], sb_q.pop_front());
                    sb_pops++;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Send one block with out_ready=1, check latency, data and the one-cycle out_valid pulse.
    task automatic send_block(input int idx, input logic [127:0] st, input logic [127:0] exp,
                              input string name);
        int cyc = 0;
        int tries = 0;
        out_ready[idx] = 1'b1;
        in_valid[idx]  = 1'b1;
        in_state[idx]  = st;
        while (!in_ready[idx] && tries < 50) begin
            tick();
            tries++;
        end
        tick();                                  // accept edge
        in_valid[idx] = 1'b0;
        while (!out_valid[idx] && cyc < 40) begin
            tick();
            cyc++;
        end
        check($sformatf("%s_latency_bpc%0d", name, bpc_of(idx)), 128'(cyc), 128'(16 / bpc_of(idx)));
        check($sformatf("%s_data_bpc%0d", name, bpc_of(idx)), out_state[idx], exp);
        tick();                                  // handoff edge
        check($sformatf("%s_valid_drop", name), 128'(out_valid[idx]), 128'(1'b0));
        check($sformatf("%s_ready_back", name), 128'(in_ready[idx]), 128'(1'b1));
    endtask

    typedef struct {
        logic [127:0] st;
        logic [127:0] exp;
    } vec_t;

    vec_t         vecs [6];
    logic [127:0] bb_states [8];
    logic [127:0] st_a;
    logic [127:0] st_b;
    logic [127:0] exp_a;
    int           target;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{128'h193de3bea0f4e22b9ac68d2ae9f84808, 128'hd42711aee0bf98f1b8b45de51e415230};
        vecs[1] = '{128'h0, {16{8'h63}}};
        vecs[2] = '{{16{8'hff}}, {16{8'h16}}};
        vecs[3] = '{{16{8'h53}}, {16{8'hed}}};
        vecs[4] = '{{16{8'h01}}, {16{8'h7c}}};
        vecs[5] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h637c777bf26b6fc53001672bfed7ab76};

        for (int i = 0; i < 256; i++) sbox_ref[i] = sbox_calc(8'(i));
        for (int g = 0; g < NINST; g++) begin
            in_valid[g]  = 1'b0;
            in_state[g]  = '0;
            out_ready[g] = 1'b1;
        end

        // Reset values while rst_n is low, then in_ready after release.
        #2;
        check("rst_in_ready", 128'(in_ready[0]), 128'(1'b0));
        check("rst_out_valid", 128'(out_valid[0]), 128'(1'b0));
        check("rst_busy", 128'(busy[0]), 128'(1'b0));
        check("rst_out_state", out_state[0], 128'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_release_ready", 128'(in_ready[0]), 128'(1'b1));

        // Table-driven vectors on the default instance.
        for (int v = 0; v < 6; v++) send_block(0, vecs[v].st, vecs[v].exp, $sformatf("vec%0d", v));

        // Exhaustive bytes 00..FF on every BYTES_PER_CYCLE value.
        for (int g = 0; g < NINST; g++) begin
            for (int b = 0; b < 16; b++) begin
                logic [127:0] st;
                for (int j = 0; j < 16; j++) st[127 - 8*j -: 8] = 8'(16*b + j);
                send_block(g, st, sub_state(st), $sformatf("exh%0d", b));
            end
        end

        // Backpressure: hold out_ready low for 10 cycles while poking in_valid.
        st_a  = {$urandom, $urandom, $urandom, $urandom};
        exp_a = sub_state(st_a);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_state[0]  = st_a;
        tick();
        in_valid[0] = 1'b0;
        for (int c = 0; c < 40 && !out_valid[0]; c++) tick();
        check("bp_valid_up", 128'(out_valid[0]), 128'(1'b1));
        for (int c = 0; c < 10; c++) begin
            check("bp_hold_state", out_state[0], exp_a);
            check("bp_hold_ready", 128'(in_ready[0]), 128'(1'b0));
            in_valid[0] = c[0];
            in_state[0] = {$urandom, $urandom, $urandom, $urandom};
            tick();
        end
        check("bp_still_valid", 128'(out_valid[0]), 128'(1'b1));
        check("bp_final_state", out_state[0], exp_a);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        tick();
        check("bp_handoff_valid", 128'(out_valid[0]), 128'(1'b0));
        check("bp_handoff_ready", 128'(in_ready[0]), 128'(1'b1));
        st_b = {$urandom, $urandom, $urandom, $urandom};
        send_block(0, st_b, sub_state(st_b), "bp_next");

        // Reset two cycles after accept; partial block is discarded.
        in_valid[0] = 1'b1;
        in_state[0] = {$urandom, $urandom, $urandom, $urandom};
        tick();
        in_valid[0] = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 128'(in_ready[0]), 128'(1'b0));
        check("mid_rst_valid", 128'(out_valid[0]), 128'(1'b0));
        check("mid_rst_state", out_state[0], 128'h0);
        check("mid_rst_busy", 128'(busy[0]), 128'(1'b0));
        tick();
        check("mid_rst_hold_state", out_state[0], 128'h0);
        check("mid_rst_hold_ready", 128'(in_ready[0]), 128'(1'b0));
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rst_release_ready", 128'(in_ready[0]), 128'(1'b1));
        send_block(0, 128'h0, {16{8'h63}}, "post_rst_zero");

        // Back-to-back with random out_ready; ordering checked by the scoreboard.
        for (int k = 0; k < 8; k++) bb_states[k] = {$urandom, $urandom, $urandom, $urandom};
        target = sb_pops + 8;
        fork
            begin
                for (int k = 0; k < 8; k++) begin
                    int tries = 0;
                    in_valid[0] = 1'b1;
                    in_state[0] = bb_states[k];
                    while (!in_ready[0] && tries < 200) begin
                        tick();
                        tries++;
                    end
                    tick();
                end
                in_valid[0] = 1'b0;
            end
            begin
                for (int c = 0; c < 2000 && sb_pops < target; c++) begin
                    out_ready[0] = 1'($urandom_range(0, 1));
                    tick();
                end
                out_ready[0] = 1'b1;
            end
        join
        check("b2b_handoffs", 128'(sb_pops), 128'(target));
        check("b2b_queue_empty", 128'(sb_q.size()), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/aes_sub_bytes_seq.md
# aes_sub_bytes_seq

Sequential AES SubBytes engine for the encryption datapath: the forward counterpart of the decryption-side inverse S-box stage. It accepts a 128-bit AES state over a valid/ready handshake and substitutes BYTES_PER_CYCLE bytes per clock through forward S-box instances. It returns the substituted state over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows in the iterative round loop.

## Interface
- BYTES_PER_CYCLE, default 4: bytes substituted per clock. Legal values are 1, 2, 4, 8 and 16; any other value fails elaboration.
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  in_state is valid this cycle.
- in_ready  out  1  engine can accept a state.
- in_state  in  128  input AES state; byte 0 is [127:120] and byte 15 is [7:0] (FIPS-197 column-major order).
- out_valid  out  1  out_state holds a complete substituted state.
- out_ready  in  1  downstream accepts out_state.
- out_state  out  128  substituted state, same byte order as in_state.
- busy  out  1  high in BUSY and DONE.

## Operation
- NCHUNK = 16 / BYTES_PER_CYCLE. Chunk k covers bytes k·BYTES_PER_CYCLE through (k+1)·BYTES_PER_CYCLE−1.
- The internal 128-bit state register is updated in place; out_state is driven directly from it.
- FSM states and transitions:
  - IDLE: in_ready=1. When in_valid=1, capture in_state, clear chunk counter, go to BUSY.
  - BUSY: each cycle, replace chunk[cnt] with S(chunk[cnt]) and increment cnt. On the cycle with cnt = NCHUNK−1, go to DONE.
  - DONE: out_valid=1. When out_ready=1, go to IDLE. Otherwise hold state and out_state stable.
- S is the FIPS-197 forward S-box: S(00)=63, S(01)=7C, S(53)=ED, S(FF)=16. It is an exact inverse of the team's inverse S-box over all 256 values.
- in_ready is 0 in BUSY and DONE. in_valid and in_state are ignored while in_ready=0. DONE does not accept a new state in the same cycle it hands one off.
- Chunk counter width is max(1, clog2(NCHUNK)). When NCHUNK=1, BUSY lasts exactly one cycle.
- out_ready has no effect outside DONE.
- Asynchronous reset, including mid-operation: state→IDLE, cnt=0, state register=0. Any partially processed block is discarded with no output.

## Timing
- Reset values: in_ready=1 once rst_n deasserts (0 while rst_n=0), out_valid=0, busy=0, out_state=128'h0.
- Accept on edge E. out_valid rises after edge E+NCHUNK. Latency is NCHUNK cycles; with the default parameter, out_valid is first seen 4 cycles after acceptance.
- Handoff on edge H, when out_valid and out_ready are both 1. in_ready is 1 in the cycle after H.
- Peak throughput is one block per NCHUNK+2 cycles.
- out_valid and out_state are registered and stable until handoff. in_ready and busy are decoded directly from the FSM state register.
- No combinational path from any input to any output.

## Structure
- Shared package aes_pkg holds:
  - AES_STATE_W = 128 and AES_BYTE_W = 8.
  - The byte-index function mapping byte i to bits [127−8i −: 8]; reuse it in ShiftRows and MixColumns.
  - The FSM state enum (IDLE, BUSY, DONE).
- Sub-module aes_sbox: purely combinational 8-bit forward S-box, input a and output c, matching the inverse S-box's port naming. Instantiate BYTES_PER_CYCLE copies in a generate loop, muxed onto the current chunk.

## Test plan
- Single block, default parameter, out_ready=1: in_state=193de3bea0f4e22b9ac68d2ae9f84808 → out_state=d42711aee0bf98f1b8b45de51e415230. out_valid is first high 4 cycles after accept and stays high for 1 cycle.
- Exhaustive S-box check: run 16 blocks covering bytes 00..FF. Every output byte must equal the FIPS-197 table (00→63, 53→ED, FF→16). Re-run with BYTES_PER_CYCLE = 1, 2, 8 and 16; latency must be 16, 8, 2 and 1 cycles respectively.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid rises.
  - out_state stays stable and in_ready stays 0 throughout.
  - Toggling in_valid with new data has no effect.
  - After handoff, the next block is accepted and processed correctly.
- Reset mid-operation: assert rst_n=0 two cycles after accept.
  - Outputs show in_ready=0, out_valid=0 and out_state=0 immediately and while rst_n=0.
  - in_ready returns to 1 after release.
  - The next block 00…00 → 6363…63 with no leftover bytes.
- Back-to-back traffic: in_valid held high with 8 random states and random out_ready. The output sequence must match the reference model in order, with no drops or duplicates.
